// File: rtl/seq_multiplier.sv
// Sequential unsigned shift-add multiplier: one N-bit adder, N iterations per product,
// a single-cycle done pulse, and registered product, overflow and zero-operand flags.
module seq_multiplier #(
  parameter int N = 10
) (
  input  logic           clk,
  input  logic           sclr,
  input  logic           start,
  input  logic [N-1:0]   in_A,
  input  logic [N-1:0]   in_B,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product,
  output logic           ovf,
  output logic           zero_op,
  output logic [1:0]     dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(N - 1);

  state_t           state_q;
  logic [N-1:0]     a_q, q_q, b_q;
  logic [3:0]       cnt_q;
  logic [2*N-1:0]   result_q;
  logic             ovf_q, zero_q;

  logic [N:0]       sum;
  logic [N-1:0]     a_d, q_d;

  // One iteration: conditionally add B into the high half, then shift A:Q right by one.
  always_comb begin
    sum = {1'b0, a_q} + (q_q[0] ? {1'b0, b_q} : '0);
    a_d = sum[N:1];
    q_d = {sum[0], q_q[N-1:1]};
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      state_q  <= IDLE;
      a_q      <= '0;
      q_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if ((in_A != '0) && (in_B != '0)) begin
              b_q     <= in_B;
              q_q     <= in_A;
              a_q     <= '0;
              cnt_q   <= '0;
              state_q <= CALC;
            end else begin
              // A zero operand short-circuits straight to DONE with a zero product.
              result_q <= '0;
              ovf_q    <= 1'b0;
              zero_q   <= 1'b1;
              state_q  <= DONE;
            end
          end
        end
        CALC: begin
          a_q   <= a_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == CNT_LAST) begin
            result_q <= {a_d, q_d};
            ovf_q    <= |a_d;
            zero_q   <= 1'b0;
            state_q  <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q == CALC);
  assign done      = (state_q == DONE);
  assign product   = result_q;
  assign ovf       = ovf_q;
  assign zero_op   = zero_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: directed corner cases plus random operands, checked against
// a plain-arithmetic product model with an expected queue.
module tb_seq_multiplier;

  localparam int N = 10;
  localparam int W = 2 * N;

  logic           clk = 1'b0;
  logic           sclr;
  logic           start;
  logic [N-1:0]   in_A, in_B;
  logic           busy, done, ovf, zero_op;
  logic [W-1:0]   product;
  logic [1:0]     dbg_state;

  int             checks = 0;
  int             failures = 0;
  logic [W-1:0]   exp_q[$];
  logic [W-1:0]   last_prod = '0;

  seq_multiplier #(.N(N)) dut (
    .clk       (clk),
    .sclr      (sclr),
    .start     (start),
    .in_A      (in_A),
    .in_B      (in_B),
    .busy      (busy),
    .done      (done),
    .product   (product),
    .ovf       (ovf),
    .zero_op   (zero_op),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Drives one operation and follows it to done (or to an abort).
  // inject_cyc / abort_cyc are 0-based CALC cycle indices, -1 to disable.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input int inject_cyc, input int abort_cyc);
    logic [W-1:0] ep, sb;
    logic         ez, eo;
    int           cycles, busy_cnt;
    ep = W'(a) * W'(b);
    ez = (a == 0) || (b == 0);
    eo = (ep >= W'(1 << N));
    exp_q.push_back(ep);

    start = 1'b1; in_A = a; in_B = b;
    @(negedge clk);
    start = 1'b0;
    cycles = 0; busy_cnt = 0;
    while (!done && cycles < 4 * N) begin
      if (busy) busy_cnt++;
      if (cycles == 0) check("hold_prod", product, last_prod);
      if (cycles == inject_cyc) begin start = 1'b1; in_A = 100; in_B = 100; end
      if (cycles == abort_cyc) sclr = 1'b1;
      @(negedge clk);
      start = 1'b0;
      sclr = 1'b0;
      cycles++;
      if (abort_cyc >= 0 && cycles == abort_cyc + 1) break;
    end

    sb = exp_q.pop_front();
    if (abort_cyc >= 0) begin
      check("abort_done", done, 0);
      check("abort_busy", busy, 0);
      check("abort_prod", product, 0);
      check("abort_ovf", ovf, 0);
      last_prod = '0;
      repeat (3) begin
        @(negedge clk);
        check("abort_quiet", done, 0);
      end
      return;
    end

    if (cycles >= 4 * N) check("timeout", 1, 0);
    check("latency", cycles, ez ? 0 : N);
    check("busy_cycles", busy_cnt, ez ? 0 : N);
    check("product", product, sb);
    check("ovf", ovf, eo);
    check("zero_op", zero_op, ez);
    check("busy_in_done", busy, 0);
    last_prod = sb;
    @(negedge clk);
    check("done_pulse", done, 0);
    check("idle_busy", busy, 0);
    check("prod_hold", product, last_prod);
  endtask

  initial begin
    sclr = 1'b1; start = 1'b0; in_A = '0; in_B = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_prod", product, 0);
    check("rst_ovf", ovf, 0);
    check("rst_zero", zero_op, 0);
    sclr = 1'b0;
    @(negedge clk);

    run_op(10'd25,   10'd40,   -1, -1);
    run_op(10'd1023, 10'd1023, -1, -1);
    run_op(10'd32,   10'd32,   -1, -1);
    run_op(10'd1,    10'd1023, -1, -1);
    run_op(10'd0,    10'd517,  -1, -1);
    run_op(10'd3,    10'd0,    -1, -1);
    run_op(10'd7,    10'd9,     3, -1);
    run_op(10'd100,  10'd100,  -1, -1);
    run_op(10'd511,  10'd511,  -1,  4);
    run_op(10'd2,    10'd3,    -1, -1);

    for (int i = 0; i < 30; i++) begin
      logic [N-1:0] ra, rb;
      ra = N'($urandom_range(0, (1 << N) - 1));
      rb = N'($urandom_range(0, (1 << N) - 1));
      if ($urandom_range(0, 7) == 0) ra = '0;
      if ($urandom_range(0, 7) == 0) rb = '0;
      run_op(ra, rb, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
